wb_master_bridge: RTL and testbench

Single-outstanding Wishbone classic (B3) initiator for the user project area. It turns a valid/ready command from local logic (LA probes or an on-chip sequencer) into one bus read or write, then returns the read data and completion status on a valid/ready response channel. It is the initiator counterpart to the user-project Wishbone responder, and it drives that responder's slave ports in block-level and loopback benches.

---
 rtl/wb_master_pkg.sv | 14 +
 rtl/wb_timeout_counter.sv | 36 +++
 rtl/wb_master_bridge.sv | 170 +++++++++++++++++
 tb/tb_wb_master_bridge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the single-outstanding Wishbone classic initiator.
package wb_master_pkg;

  localparam int WB_DAT_W               = 32;
  localparam int WB_SEL_W               = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating bus-cycle counter; expired is high while the count equals MAX_COUNT.
module wb_timeout_counter
  import wb_master_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count;

  // Count wait cycles; holds at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else if (clr) begin
      count <= {CNT_W{1'b0}};
    end else if (en && (count != SAT)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/wb_master_bridge.sv
// Valid/ready command to Wishbone classic initiator, one transaction in flight.
// Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_bridge
  import wb_master_pkg::*;
#(
  parameter int ADR_W          = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADR_W-1:0]    cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]    wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  state_t state, next_state;

  logic                cyc_nx, stb_nx, we_nx;
  logic [WB_SEL_W-1:0] sel_nx;
  logic [ADR_W-1:0]    adr_nx;
  logic [WB_DAT_W-1:0] wdat_nx;
  logic                rsp_valid_nx, rsp_err_nx;
  logic [WB_DAT_W-1:0] rsp_dat_nx;
  logic                timeout;

`ifdef WB_MASTER_TIMEOUT_EN
  logic bus_wait;
  assign bus_wait = (state == S_BUS) && !wbm_ack_i && !wbm_err_i;

  wb_timeout_counter #(
    .MAX_COUNT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .clr    (state != S_BUS),
    .en     (bus_wait),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Ready only when idle and out of reset.
  assign cmd_ready_o = wb_rst_ni && (state == S_IDLE);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    next_state   = state;
    cyc_nx       = wbm_cyc_o;
    stb_nx       = wbm_stb_o;
    we_nx        = wbm_we_o;
    sel_nx       = wbm_sel_o;
    adr_nx       = wbm_adr_o;
    wdat_nx      = wbm_dat_o;
    rsp_valid_nx = rsp_valid_o;
    rsp_dat_nx   = rsp_dat_o;
    rsp_err_nx   = rsp_err_o;
    case (state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          next_state = S_BUS;
          cyc_nx     = 1'b1;
          stb_nx     = 1'b1;
          we_nx      = cmd_we_i;
          sel_nx     = cmd_sel_i;
          adr_nx     = cmd_adr_i;
          wdat_nx    = cmd_dat_i;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_BUS: begin
        // err wins over a simultaneous ack; any termination wins over timeout.
        if (wbm_err_i) begin
          next_state   = S_RESP;
          cyc_nx       = 1'b0;
          stb_nx       = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_dat_nx   = 32'h0000_0000;
          rsp_err_nx   = 1'b1;
        end else if (wbm_ack_i) begin
          next_state   = S_RESP;
          cyc_nx       = 1'b0;
          stb_nx       = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_dat_nx   = wbm_we_o ? 32'h0000_0000 : wbm_dat_i;
          rsp_err_nx   = 1'b0;
        end else if (timeout) begin
          next_state   = S_RESP;
          cyc_nx       = 1'b0;
          stb_nx       = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_dat_nx   = 32'h0000_0000;
          rsp_err_nx   = 1'b1;
        end else begin
          next_state = S_BUS;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          next_state   = S_IDLE;
          rsp_valid_nx = 1'b0;
          rsp_dat_nx   = 32'h0000_0000;
          rsp_err_nx   = 1'b0;
        end else begin
          next_state = S_RESP;
        end
      end
      default: begin
        next_state   = S_IDLE;
        cyc_nx       = 1'b0;
        stb_nx       = 1'b0;
        rsp_valid_nx = 1'b0;
        rsp_dat_nx   = 32'h0000_0000;
        rsp_err_nx   = 1'b0;
      end
    endcase
  end

  // Output registers; reset drops cyc/stb and discards any pending response.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= {WB_SEL_W{1'b0}};
      wbm_adr_o   <= {ADR_W{1'b0}};
      wbm_dat_o   <= {WB_DAT_W{1'b0}};
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= {WB_DAT_W{1'b0}};
      rsp_err_o   <= 1'b0;
    end else begin
      wbm_cyc_o   <= cyc_nx;
      wbm_stb_o   <= stb_nx;
      wbm_we_o    <= we_nx;
      wbm_sel_o   <= sel_nx;
      wbm_adr_o   <= adr_nx;
      wbm_dat_o   <= wdat_nx;
      rsp_valid_o <= rsp_valid_nx;
      rsp_dat_o   <= rsp_dat_nx;
      rsp_err_o   <= rsp_err_nx;
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed self-checking bench for wb_master_bridge (TIMEOUT_CYCLES = 4).
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_master_bridge #(.ADR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_dat_i(rdat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    cmd_sel = 4'h0; rsp_ready = 1'b0; ack = 1'b0; err = 1'b0; rdat = 32'h0;
    tick(); tick();
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("rst_cyc", {31'h0, cyc}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // Write, responder acks after two wait states.
    offer(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    tick();
    cmd_valid = 1'b0;
    check("wr_cyc", {31'h0, cyc}, 32'h1);
    check("wr_stb", {31'h0, stb}, 32'h1);
    check("wr_we", {31'h0, we}, 32'h1);
    check("wr_adr", adr, 32'h3000_0004);
    check("wr_dat", wdat, 32'hA5A5_1234);
    check("wr_sel", {28'h0, sel}, 32'hF);
    check("wr_busy_ready", {31'h0, cmd_ready}, 32'h0);
    tick();
    check("wr_wait2_stb", {31'h0, stb}, 32'h1);
    tick();
    check("wr_wait3_rsp", {31'h0, rsp_valid}, 32'h0);
    ack = 1'b1; rdat = 32'h5555_AAAA;
    tick();
    ack = 1'b0; rdat = 32'h0;
    check("wr_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("wr_rsp_dat", rsp_dat, 32'h0);
    check("wr_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("wr_cyc_low", {31'h0, cyc}, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_done_valid", {31'h0, rsp_valid}, 32'h0);
    check("wr_done_ready", {31'h0, cmd_ready}, 32'h1);

    // Stray ack in IDLE is ignored.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_ack_cyc", {31'h0, cyc}, 32'h0);
    check("idle_ack_rsp", {31'h0, rsp_valid}, 32'h0);

    // Zero-wait read.
    offer(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    check("rd_we", {31'h0, we}, 32'h0);
    ack = 1'b1; rdat = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0; rdat = 32'h0;
    check("rd_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rd_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
    check("rd_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rd_bus_idle", {31'h0, stb}, 32'h0);

    // Backpressure with a new command waiting and a stray ack.
    offer(1'b1, 32'h3000_000C, 32'h1111_2222, 4'h3);
    for (int i = 0; i < 5; i++) begin
      ack = (i == 2);
      tick();
      check("bp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_dat", rsp_dat, 32'hDEAD_BEEF);
      check("bp_ready", {31'h0, cmd_ready}, 32'h0);
      check("bp_cyc", {31'h0, cyc}, 32'h0);
    end
    ack = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_release_ready", {31'h0, cmd_ready}, 32'h1);
    check("bp_release_cyc", {31'h0, cyc}, 32'h0);
    tick();
    cmd_valid = 1'b0;
    check("bp_next_cyc", {31'h0, cyc}, 32'h1);
    check("bp_next_adr", adr, 32'h3000_000C);
    check("bp_next_sel", {28'h0, sel}, 32'h3);

    // ack and err together: err wins.
    ack = 1'b1; err = 1'b1; rdat = 32'h7777_7777;
    tick();
    ack = 1'b0; err = 1'b0; rdat = 32'h0;
    check("ackerr_valid", {31'h0, rsp_valid}, 32'h1);
    check("ackerr_err", {31'h0, rsp_err}, 32'h1);
    check("ackerr_dat", rsp_dat, 32'h0);
    tick();
    rsp_ready = 1'b0;
    check("ackerr_done", {31'h0, cmd_ready}, 32'h1);

`ifdef WB_MASTER_TIMEOUT_EN
    // No termination: stb high for exactly 5 cycles, then error.
    offer(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("to_stb_high", {31'h0, stb}, 32'h1);
      tick();
    end
    check("to_stb_low", {31'h0, stb}, 32'h0);
    check("to_valid", {31'h0, rsp_valid}, 32'h1);
    check("to_err", {31'h0, rsp_err}, 32'h1);
    check("to_dat", rsp_dat, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Ack on the expiry cycle completes normally.
    offer(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("to_edge_stb", {31'h0, stb}, 32'h1);
    ack = 1'b1; rdat = 32'h1234_5678;
    tick();
    ack = 1'b0; rdat = 32'h0;
    check("to_edge_valid", {31'h0, rsp_valid}, 32'h1);
    check("to_edge_err", {31'h0, rsp_err}, 32'h0);
    check("to_edge_dat", rsp_dat, 32'h1234_5678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    offer(1'b1, 32'h3000_0018, 32'h0BAD_0BAD, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
`else
    // Without timeout the bus waits indefinitely.
    offer(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    check("hang_cyc", {31'h0, cyc}, 32'h1);
    check("hang_stb", {31'h0, stb}, 32'h1);
    check("hang_rsp", {31'h0, rsp_valid}, 32'h0);
    check("hang_ready", {31'h0, cmd_ready}, 32'h0);
`endif

    // Reset while in BUS.
    check("prerst_cyc", {31'h0, cyc}, 32'h1);
    rst_n = 1'b0;
    tick();
    check("midrst_cyc", {31'h0, cyc}, 32'h0);
    check("midrst_stb", {31'h0, stb}, 32'h0);
    check("midrst_rsp", {31'h0, rsp_valid}, 32'h0);
    check("midrst_ready", {31'h0, cmd_ready}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("postrst_ready", {31'h0, cmd_ready}, 32'h1);
    check("postrst_rsp", {31'h0, rsp_valid}, 32'h0);
    offer(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    check("postrst_cyc", {31'h0, cyc}, 32'h1);
    ack = 1'b1; rdat = 32'hCAFE_F00D;
    tick();
    ack = 1'b0; rdat = 32'h0;
    check("postrst_valid", {31'h0, rsp_valid}, 32'h1);
    check("postrst_dat", rsp_dat, 32'hCAFE_F00D);
    check("postrst_err", {31'h0, rsp_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
